// File: rtl/carregador_pkg.sv
// rtl/carregador_pkg.sv - shared state encoding and constants for the program loader
package carregador_pkg;

   typedef enum logic [2:0] {
      ESPERA_TAM = 3'd0,
      CARGA      = 3'd1,
      CHECA      = 3'd2,
      PRONTO     = 3'd3,
      ERRO       = 3'd4
   } estado_t;

   localparam logic [7:0] LEN_INVALIDO = 8'h00;

endpackage

// File: rtl/acumulador_checksum.sv
// rtl/acumulador_checksum.sv - running mod-256 byte sum; ok flags that adding 'in' closes the sum to zero
module acumulador_checksum (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] in,
   output logic [7:0] soma,
   output logic       ok
);

   logic [7:0] r_soma;
   logic [7:0] w_prox;

   assign w_prox = r_soma + in;
   assign soma   = r_soma;
   assign ok     = (w_prox == 8'h00);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_soma <= 8'h00;
      else if (clr)
         r_soma <= 8'h00;
      else if (en)
         r_soma <= w_prox;
   end

endmodule

// File: rtl/carregador_programa.sv
// rtl/carregador_programa.sv - boot loader: framed byte stream into instruction memory, holds CPU in reset
// Optional checksum byte and CHECA state enabled by defining CARREGADOR_CHECKSUM_EN.
module carregador_programa #(
   parameter int                   ADDR_BITS  = 8,
   parameter logic [ADDR_BITS-1:0] START_ADDR = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [7:0]           in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 mem_we,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [7:0]           mem_data,
   output logic                 proc_reset,
   output logic                 busy,
   output logic                 done,
   output logic                 erro
);
   import carregador_pkg::*;

   estado_t              r_state, w_next;
   logic [7:0]           r_len, r_cnt;
   logic                 r_mem_we, r_proc_reset;
   logic [ADDR_BITS-1:0] r_mem_addr, w_off;
   logic [7:0]           r_mem_data;
   logic                 w_xfer, w_last, w_aceita;

   assign w_aceita = (r_state == ESPERA_TAM) || (r_state == CARGA) || (r_state == CHECA);
   assign in_ready = w_aceita & ~start;
   assign w_xfer   = in_valid & in_ready;
   assign w_last   = (r_cnt == r_len - 8'd1);
   assign w_off    = ADDR_BITS'(r_cnt);

`ifdef CARREGADOR_CHECKSUM_EN
   logic [7:0] w_soma;
   logic       w_ok;

   acumulador_checksum u_soma (
      .clk   (clk),
      .reset (reset),
      .clr   (start),
      .en    (w_xfer & ((r_state == ESPERA_TAM) || (r_state == CARGA))),
      .in    (in_data),
      .soma  (w_soma),
      .ok    (w_ok)
   );
`endif

   always_comb begin
      w_next = r_state;
      if (start) begin
         w_next = ESPERA_TAM;
      end else begin
         case (r_state)
            ESPERA_TAM: if (w_xfer) w_next = (in_data == LEN_INVALIDO) ? ERRO : CARGA;
`ifdef CARREGADOR_CHECKSUM_EN
            CARGA:      if (w_xfer && w_last) w_next = CHECA;
            CHECA:      if (w_xfer) w_next = w_ok ? PRONTO : ERRO;
`else
            CARGA:      if (w_xfer && w_last) w_next = PRONTO;
`endif
            default:    w_next = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ESPERA_TAM;
         r_len        <= 8'h00;
         r_cnt        <= 8'h00;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= START_ADDR;
         r_mem_data   <= 8'h00;
         r_proc_reset <= 1'b1;
      end else begin
         r_state  <= w_next;
         r_mem_we <= 1'b0;
         // Release lags PRONTO entry by one edge so the last write lands first.
         r_proc_reset <= !((r_state == PRONTO) && !start);
         if (start) begin
            r_cnt      <= 8'h00;
            r_mem_addr <= START_ADDR;
         end else if (w_xfer) begin
            if (r_state == ESPERA_TAM) begin
               r_len <= in_data;
               r_cnt <= 8'h00;
            end else if (r_state == CARGA) begin
               r_mem_we   <= 1'b1;
               r_mem_addr <= START_ADDR + w_off;
               r_mem_data <= in_data;
               r_cnt      <= r_cnt + 8'd1;
            end
         end
      end
   end

   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_data   = r_mem_data;
   assign proc_reset = r_proc_reset;
   assign busy       = w_aceita;
   assign done       = (r_state == PRONTO);
   assign erro       = (r_state == ERRO);

endmodule

// File: tb/tb_carregador_programa.sv
// tb/tb_carregador_programa.sv - table-driven bench for carregador_programa (both CARREGADOR_CHECKSUM_EN builds)
module tb_carregador_programa;

   logic       clk = 1'b0;
   logic       reset, start, in_valid;
   logic [7:0] in_data;

   logic       in_ready, mem_we, proc_reset, busy, done, erro;
   logic [7:0] mem_addr, mem_data;
   logic       in_ready_fe, mem_we_fe, proc_reset_fe, busy_fe, done_fe, erro_fe;
   logic [7:0] mem_addr_fe, mem_data_fe;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   carregador_programa #(.ADDR_BITS(8), .START_ADDR(8'h00)) dut (
      .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
      .proc_reset(proc_reset), .busy(busy), .done(done), .erro(erro)
   );

   carregador_programa #(.ADDR_BITS(8), .START_ADDR(8'hFE)) dut_fe (
      .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_fe), .mem_we(mem_we_fe), .mem_addr(mem_addr_fe), .mem_data(mem_data_fe),
      .proc_reset(proc_reset_fe), .busy(busy_fe), .done(done_fe), .erro(erro_fe)
   );

   typedef struct {
      logic       st, v;
      logic [7:0] d;
      logic       rdy;
      logic       we;
      logic [7:0] addr, data;
      logic       prst, busy, done, erro;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(logic st, logic v, logic [7:0] d, logic rdy, logic we,
                               logic [7:0] addr, logic [7:0] data,
                               logic prst, logic b, logic dn, logic e);
      vec_t x;
      x.st = st; x.v = v; x.d = d; x.rdy = rdy; x.we = we; x.addr = addr; x.data = data;
      x.prst = prst; x.busy = b; x.done = dn; x.erro = e;
      tbl.push_back(x);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [20:0] obs();
      return {mem_we, mem_addr, mem_data, proc_reset, busy, done, erro};
   endfunction

   task automatic push(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      #1;
      chk($sformatf("push_%h_rdy", d), {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", {11'd0, obs()}, {11'd0, 1'b0, 8'h00, 8'h00, 4'b1100});
      chk("reset_fe_addr", {24'd0, mem_addr_fe}, 32'h0000_00FE);
      chk("reset_ready", {31'd0, in_ready}, 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // good frame 03 A1 B2 C3 (+ CHK E7), with one idle cycle mid-frame
      add(0,1,8'h03, 1, 0,8'h00,8'h00, 1,1,0,0);
      add(0,1,8'hA1, 1, 1,8'h00,8'hA1, 1,1,0,0);
      add(0,0,8'hFF, 1, 0,8'h00,8'hA1, 1,1,0,0);
      add(0,1,8'hB2, 1, 1,8'h01,8'hB2, 1,1,0,0);
`ifdef CARREGADOR_CHECKSUM_EN
      add(0,1,8'hC3, 1, 1,8'h02,8'hC3, 1,1,0,0);
      add(0,1,8'hE7, 1, 0,8'h02,8'hC3, 1,0,1,0);
`else
      add(0,1,8'hC3, 1, 1,8'h02,8'hC3, 1,0,1,0);
`endif
      add(0,1,8'h55, 0, 0,8'h02,8'hC3, 0,0,1,0);
      add(0,0,8'h00, 0, 0,8'h02,8'hC3, 0,0,1,0);
      add(1,1,8'h07, 0, 0,8'h00,8'hC3, 1,1,0,0);
      // LEN=0 goes to ERRO, which accepts nothing until start
      add(0,1,8'h00, 1, 0,8'h00,8'hC3, 1,0,0,1);
      add(0,1,8'h04, 0, 0,8'h00,8'hC3, 1,0,0,1);
      add(1,0,8'h00, 0, 0,8'h00,8'hC3, 1,1,0,0);
      // start mid-frame with in_valid high: byte not consumed, next byte is LEN
      add(0,1,8'h04, 1, 0,8'h00,8'hC3, 1,1,0,0);
      add(0,1,8'h11, 1, 1,8'h00,8'h11, 1,1,0,0);
      add(0,1,8'h22, 1, 1,8'h01,8'h22, 1,1,0,0);
      add(1,1,8'h33, 0, 0,8'h00,8'h22, 1,1,0,0);
      add(0,1,8'h02, 1, 0,8'h00,8'h22, 1,1,0,0);
      add(0,1,8'h44, 1, 1,8'h00,8'h44, 1,1,0,0);
`ifdef CARREGADOR_CHECKSUM_EN
      add(0,1,8'h66, 1, 1,8'h01,8'h66, 1,1,0,0);
      add(0,1,8'h00, 1, 0,8'h01,8'h66, 1,0,0,1);
      add(0,1,8'h12, 0, 0,8'h01,8'h66, 1,0,0,1);
`else
      add(0,1,8'h66, 1, 1,8'h01,8'h66, 1,0,1,0);
      add(0,0,8'h00, 0, 0,8'h01,8'h66, 0,0,1,0);
`endif
      add(1,0,8'h00, 0, 0,8'h00,8'h66, 1,1,0,0);

      for (int i = 0; i < tbl.size(); i++) begin
         start    = tbl[i].st;
         in_valid = tbl[i].v;
         in_data  = tbl[i].d;
         #1;
         chk($sformatf("v%0d_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].rdy});
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_out", i), {11'd0, obs()},
             {11'd0, tbl[i].we, tbl[i].addr, tbl[i].data,
              tbl[i].prst, tbl[i].busy, tbl[i].done, tbl[i].erro});
      end
      start = 1'b0; in_valid = 1'b0;

      // address wrap on the START_ADDR=FE instance
      push(8'h03);
      push(8'h10);
      chk("wrap_w0", {15'd0, mem_we_fe, mem_addr_fe, mem_data_fe}, {15'd0, 1'b1, 8'hFE, 8'h10});
      push(8'h20);
      chk("wrap_w1", {15'd0, mem_we_fe, mem_addr_fe, mem_data_fe}, {15'd0, 1'b1, 8'hFF, 8'h20});
      push(8'h30);
      chk("wrap_w2", {15'd0, mem_we_fe, mem_addr_fe, mem_data_fe}, {15'd0, 1'b1, 8'h00, 8'h30});
      chk("wrap_main_addr", {24'd0, mem_addr}, 32'h0000_0002);
      chk("wrap_prst_held", {31'd0, proc_reset_fe}, 32'd1);
`ifdef CARREGADOR_CHECKSUM_EN
      push(8'h9D);
`endif
      chk("wrap_done", {30'd0, done_fe, erro_fe}, 32'd2);
      @(posedge clk);
      #1;
      chk("wrap_prst_rel", {30'd0, proc_reset_fe, mem_we_fe}, 32'd0);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("wrap_restart", {22'd0, busy_fe, proc_reset_fe, mem_addr_fe}, {22'd0, 2'b11, 8'hFE});

      // asynchronous reset in the middle of CARGA, then a clean reload
      push(8'h05);
      push(8'hAA);
      chk("mid_write", {15'd0, mem_we, mem_addr, mem_data}, {15'd0, 1'b1, 8'h00, 8'hAA});
      reset = 1'b0;
      #1;
      chk("mid_reset", {11'd0, obs()}, {11'd0, 1'b0, 8'h00, 8'h00, 4'b1100});
      @(posedge clk);
      #1;
      reset = 1'b1;
      push(8'h02);
      push(8'h5A);
      chk("reload_w0", {15'd0, mem_we, mem_addr, mem_data}, {15'd0, 1'b1, 8'h00, 8'h5A});
      push(8'hA5);
      chk("reload_w1", {15'd0, mem_we, mem_addr, mem_data}, {15'd0, 1'b1, 8'h01, 8'hA5});
`ifdef CARREGADOR_CHECKSUM_EN
      push(8'hFF);
`endif
      chk("reload_done", {29'd0, done, erro, proc_reset}, 32'd5);
      @(posedge clk);
      #1;
      chk("reload_prst", {29'd0, done, proc_reset, mem_we}, 32'd4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
